// File: rtl/param_loaddataserializer_pkg.sv
// Shared encodings for the load-data serializer: load sizes, FSM states,
// word geometry and the misalignment rule.
`timescale 1ns/1ps
package param_loaddataserializer_pkg;

  localparam int C_N_OFF   = 8;
  localparam int C_OFFBITS = 3;

  typedef enum logic [1:0] {
    LD_SIZE_B    = 2'b00,
    LD_SIZE_H    = 2'b01,
    LD_SIZE_W    = 2'b10,
    LD_SIZE_RSVD = 2'b11
  } ld_size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Halfwords must be even, words must be word-aligned, reserved size is always flagged.
  function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (ld_size_e'(size))
      LD_SIZE_H:    return addr_lo[0];
      LD_SIZE_W:    return addr_lo != 2'b00;
      LD_SIZE_RSVD: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/param_loaddataserializer_alignext.sv
// Combinational load alignment: shifts the addressed lane down to bit 0 and
// sign/zero-extends bytes and halfwords to a full 32-bit word.
`timescale 1ns/1ps
module param_loadalignext
  import param_loaddataserializer_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] word
);

  logic [31:0] s;
  logic        ext_b;
  logic        ext_h;

  assign s     = data >> {addr_lo, 3'b000};
  assign ext_b = ~is_unsigned & s[7];
  assign ext_h = ~is_unsigned & s[15];

  always_comb begin
    word = s;
    case (ld_size_e'(size))
      LD_SIZE_B: word = {{24{ext_b}}, s[7:0]};
      LD_SIZE_H: word = {{16{ext_h}}, s[15:0]};
      default:   word = s;
    endcase
  end

endmodule

// File: rtl/param_loaddataserializer.sv
// Word-to-nibble load serializer, LSB nibble first, one nibble per nib_en.
// Optional misalignment pulse built only when PARAM_LD_MISALIGN_CHK_EN is defined.
`timescale 1ns/1ps
module param_loaddataserializer #(
  parameter int P_NBITS   = 4,
  parameter int C_N_OFF   = param_loaddataserializer_pkg::C_N_OFF,
  parameter int C_OFFBITS = param_loaddataserializer_pkg::C_OFFBITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_resp_val,
  output logic                 mem_resp_rdy,
  input  logic [31:0]          mem_resp_data,
  input  logic [1:0]           ld_addr_lo,
  input  logic [1:0]           ld_size,
  input  logic                 ld_unsigned,
  input  logic                 nib_en,
  output logic                 nib_val,
  output logic [P_NBITS-1:0]   nib_out,
  output logic [C_OFFBITS-1:0] nib_idx,
  output logic                 nib_last,
  output logic                 ld_misalign_err
);
  import param_loaddataserializer_pkg::*;

  localparam logic [C_OFFBITS-1:0] LAST_IDX = C_OFFBITS'(C_N_OFF - 1);

  state_e               state_reg, state_next;
  logic [C_OFFBITS-1:0] cnt_reg, cnt_next;
  logic [31:0]          shreg_reg, shreg_next;
  logic [31:0]          aligned;
  logic                 last_beat;
  logic                 accept;

  param_loadalignext u_align (
    .data        (mem_resp_data),
    .addr_lo     (ld_addr_lo),
    .size        (ld_size),
    .is_unsigned (ld_unsigned),
    .word        (aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shreg_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
    end
  end

  // Ready during the last consumed beat lets a new word follow with no bubble.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    shreg_next   = shreg_reg;
    last_beat    = (state_reg == SHIFT) && (cnt_reg == LAST_IDX) && nib_en;
    mem_resp_rdy = (state_reg == IDLE) || last_beat;
    accept       = mem_resp_val && mem_resp_rdy;

    case (state_reg)
      SHIFT: begin
        if (nib_en) begin
          shreg_next = {shreg_reg[P_NBITS-1:0], shreg_reg[31:P_NBITS]};
          cnt_next   = cnt_reg + C_OFFBITS'(1);
        end
        if (last_beat) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      shreg_next = aligned;
      cnt_next   = '0;
      state_next = SHIFT;
    end
  end

  assign nib_val  = (state_reg == SHIFT);
  assign nib_out  = shreg_reg[P_NBITS-1:0];
  assign nib_idx  = cnt_reg;
  assign nib_last = (state_reg == SHIFT) && (cnt_reg == LAST_IDX);

`ifdef PARAM_LD_MISALIGN_CHK_EN
  logic err_reg;

  // One-cycle pulse aligned with nibble 0 of the offending load.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= accept && ld_misaligned(ld_size, ld_addr_lo);
    end
  end

  assign ld_misalign_err = err_reg;
`else
  assign ld_misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_param_loaddataserializer.sv
// Self-checking bench for param_loaddataserializer: directed table, hand
// sequences for back-to-back and mid-word reset, and randomized loads vs a model.
`timescale 1ns/1ps
module tb_param_loaddataserializer;

`ifdef PARAM_LD_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_resp_val;
  logic        mem_resp_rdy;
  logic [31:0] mem_resp_data;
  logic [1:0]  ld_addr_lo;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        nib_en;
  logic        nib_val;
  logic [3:0]  nib_out;
  logic [2:0]  nib_idx;
  logic        nib_last;
  logic        ld_misalign_err;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_loaddataserializer dut (
    .clk             (clk),
    .reset           (reset),
    .mem_resp_val    (mem_resp_val),
    .mem_resp_rdy    (mem_resp_rdy),
    .mem_resp_data   (mem_resp_data),
    .ld_addr_lo      (ld_addr_lo),
    .ld_size         (ld_size),
    .ld_unsigned     (ld_unsigned),
    .nib_en          (nib_en),
    .nib_val         (nib_val),
    .nib_out         (nib_out),
    .nib_idx         (nib_idx),
    .nib_last        (nib_last),
    .ld_misalign_err (ld_misalign_err)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  a;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] exp_word;
    logic        exp_err;
    int          mode;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the load rules.
  function automatic logic [31:0] ref_word(input logic [31:0] d, input logic [1:0] a,
                                           input logic [1:0] sz, input logic u);
    int unsigned s, v, div;
    div = 1;
    for (int k = 0; k < int'(a); k++) div = div * 256;
    s = d / div;
    case (sz)
      2'd0: begin
        v = s % 256;
        if (!u && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = s % 65536;
        if (!u && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = s;
    endcase
    return v;
  endfunction

  function automatic logic ref_err(input logic [1:0] a, input logic [1:0] sz);
    return (sz == 2'd1 && (a % 2) == 1) || (sz == 2'd2 && a != 0) || (sz == 2'd3);
  endfunction

  function automatic logic [3:0] ref_nib(input logic [31:0] w, input int i);
    int unsigned div;
    div = 1;
    for (int k = 0; k < i; k++) div = div * 16;
    return 4'((int'(w) >= 0 ? w : w) / div % 16);
  endfunction

  // Called at posedge+1 in IDLE; returns at posedge+1 right after the accept edge.
  task automatic start_load(input logic [31:0] d, input logic [1:0] a, input logic [1:0] sz,
                            input logic u);
    mem_resp_val  = 1'b1;
    mem_resp_data = d;
    ld_addr_lo    = a;
    ld_size       = sz;
    ld_unsigned   = u;
    nib_en        = 1'b0;
    #4;
    chk("rdy_before_accept", 32'(mem_resp_rdy), 32'd1);
    @(posedge clk); #1;
    mem_resp_val = 1'b0;
  endtask

  // Walks the 8 nibbles of an accepted word. mode 0: nib_en always 1;
  // mode 1: nib_en 1,0,0 repeating; mode 2: random nib_en plus ignored junk requests.
  task automatic present(input logic [31:0] w, input logic e, input int mode, input bit chain,
                         input logic [31:0] nd, input logic [1:0] na, input logic [1:0] nsz,
                         input logic nu);
    int i, cyc;
    logic en;
    i = 0;
    cyc = 0;
    $display("word %08h err %0b mode %0d chain %0b", w, e & CHK, mode, chain);
    while (i < 8) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = (cyc % 3) == 0;
        default: en = 1'($urandom_range(0, 1));
      endcase
      nib_en = en;
      if (i == 7) begin
        mem_resp_val  = chain;
        mem_resp_data = nd;
        ld_addr_lo    = na;
        ld_size       = nsz;
        ld_unsigned   = nu;
      end else if (mode == 2) begin
        mem_resp_val  = 1'($urandom_range(0, 1));
        mem_resp_data = $urandom;
        ld_addr_lo    = 2'($urandom_range(0, 3));
        ld_size       = 2'($urandom_range(0, 3));
        ld_unsigned   = 1'($urandom_range(0, 1));
      end
      #4;
      chk("nib_val", 32'(nib_val), 32'd1);
      chk("nib_out", 32'(nib_out), 32'(ref_nib(w, i)));
      chk("nib_idx", 32'(nib_idx), 32'(i));
      chk("nib_last", 32'(nib_last), 32'(i == 7));
      chk("rdy_shift", 32'(mem_resp_rdy), 32'(i == 7 && en));
      chk("misalign_err", 32'(ld_misalign_err), 32'(cyc == 0 && e && CHK));
      @(posedge clk); #1;
      mem_resp_val = 1'b0;
      if (en) i++;
      cyc++;
      if (cyc > 200) begin
        chk("advance_timeout", 32'(i), 32'd8);
        i = 8;
      end
    end
    nib_en = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    #4;
    chk({nm, "_nib_val"}, 32'(nib_val), 32'd0);
    chk({nm, "_nib_last"}, 32'(nib_last), 32'd0);
    chk({nm, "_rdy"}, 32'(mem_resp_rdy), 32'd1);
    chk({nm, "_err"}, 32'(ld_misalign_err), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] cd, nd;
    logic [1:0]  ca, csz, na, nsz;
    logic        cu, nu;
    bit          chain;

    tbl[0] = '{32'h89AB_CDEF, 2'd0, 2'd2, 1'b0, 32'h89AB_CDEF, 1'b0, 0};
    tbl[1] = '{32'h0080_0000, 2'd2, 2'd0, 1'b0, 32'hFFFF_FF80, 1'b0, 0};
    tbl[2] = '{32'h0080_0000, 2'd2, 2'd0, 1'b1, 32'h0000_0080, 1'b0, 0};
    tbl[3] = '{32'hBEEF_0000, 2'd2, 2'd1, 1'b0, 32'hFFFF_BEEF, 1'b0, 1};
    tbl[4] = '{32'hBEEF_0000, 2'd2, 2'd1, 1'b1, 32'h0000_BEEF, 1'b0, 0};
    tbl[5] = '{32'h1234_5678, 2'd1, 2'd1, 1'b0, 32'h0000_3456, 1'b1, 0};
    tbl[6] = '{32'h1234_5678, 2'd3, 2'd0, 1'b0, 32'h0000_0012, 1'b0, 1};
    tbl[7] = '{32'hCAFE_F00D, 2'd1, 2'd2, 1'b0, 32'h00CA_FEF0, 1'b1, 0};
    tbl[8] = '{32'hCAFE_F00D, 2'd2, 2'd3, 1'b1, 32'h0000_CAFE, 1'b1, 0};
    tbl[9] = '{32'h7F00_FF01, 2'd1, 2'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1};

    reset = 1'b1;
    mem_resp_val = 1'b0;
    mem_resp_data = '0;
    ld_addr_lo = '0;
    ld_size = '0;
    ld_unsigned = 1'b0;
    nib_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #4;
    chk("reset_nib_val", 32'(nib_val), 32'd0);
    chk("reset_rdy", 32'(mem_resp_rdy), 32'd1);
    chk("reset_nib_idx", 32'(nib_idx), 32'd0);
    chk("reset_nib_out", 32'(nib_out), 32'd0);
    chk("reset_nib_last", 32'(nib_last), 32'd0);
    chk("reset_err", 32'(ld_misalign_err), 32'd0);
    @(posedge clk); #1;

    // Directed table
    for (int t = 0; t < 10; t++) begin
      start_load(tbl[t].data, tbl[t].a, tbl[t].sz, tbl[t].u);
      present(tbl[t].exp_word, tbl[t].exp_err, tbl[t].mode, 1'b0, '0, '0, '0, 1'b0);
      check_idle("after_tbl");
    end

    // Back-to-back words: no bubble between last beat and next nibble 0
    start_load(32'h89AB_CDEF, 2'd0, 2'd2, 1'b0);
    present(32'h89AB_CDEF, 1'b0, 0, 1'b1, 32'h0123_4567, 2'd0, 2'd2, 1'b0);
    present(32'h0123_4567, 1'b0, 0, 1'b0, '0, '0, '0, 1'b0);
    check_idle("after_b2b");

    // Reset while nibble 4 is presented, with nib_en and val asserted
    start_load(32'h1357_9BDF, 2'd0, 2'd2, 1'b0);
    nib_en = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    mem_resp_val = 1'b1;
    mem_resp_data = 32'hFFFF_FFFF;
    reset = 1'b1;
    #4;
    chk("pre_reset_idx", 32'(nib_idx), 32'd4);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_resp_val = 1'b0;
    nib_en = 1'b0;
    #4;
    chk("midreset_nib_val", 32'(nib_val), 32'd0);
    chk("midreset_rdy", 32'(mem_resp_rdy), 32'd1);
    chk("midreset_nib_idx", 32'(nib_idx), 32'd0);
    @(posedge clk); #1;
    start_load(32'h2468_ACE0, 2'd0, 2'd2, 1'b1);
    present(32'h2468_ACE0, 1'b0, 0, 1'b0, '0, '0, '0, 1'b0);
    check_idle("after_midreset");

    // Randomized loads with random stalls and random chaining
    cd = $urandom; ca = 2'($urandom_range(0, 3)); csz = 2'($urandom_range(0, 3));
    cu = 1'($urandom_range(0, 1));
    start_load(cd, ca, csz, cu);
    for (int k = 0; k < 24; k++) begin
      nd = $urandom; na = 2'($urandom_range(0, 3)); nsz = 2'($urandom_range(0, 3));
      nu = 1'($urandom_range(0, 1));
      chain = (k < 23) && ($urandom_range(0, 1) == 1);
      present(ref_word(cd, ca, csz, cu), ref_err(ca, csz), 2, chain, nd, na, nsz, nu);
      if (!chain) begin
        check_idle("after_rand");
        if (k < 23) start_load(nd, na, nsz, nu);
      end
      cd = nd; ca = na; csz = nsz; cu = nu;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
